// File: rtl/conv_tap_sequencer.sv
// Tap sequencer for the 2D-convolution MAC: for each output pixel it loads the bias,
// issues K*K X/W memory tap addresses, drains the MAC, and hands the result downstream.
module conv_tap_sequencer #(
    parameter int INW  = 16,
    parameter int OUTW = 64,
    parameter int MAXR = 16,
    parameter int MAXC = 16,
    parameter int MAXK = 8,
    parameter int XAW  = $clog2(MAXR*MAXC),
    parameter int WAW  = $clog2(MAXK*MAXK)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(MAXR+1)-1:0]  r_in,
    input  logic [$clog2(MAXC+1)-1:0]  c_in,
    input  logic [$clog2(MAXK+1)-1:0]  k_in,
    input  logic [INW-1:0]             bias,
    output logic                       busy,
    output logic                       done,
    output logic [XAW-1:0]             x_addr,
    output logic [WAW-1:0]             w_addr,
    output logic                       mac_init_acc,
    output logic [INW-1:0]             mac_init_value,
    output logic                       mac_input_valid,
    input  logic [OUTW-1:0]            mac_out,
    output logic [OUTW-1:0]            out_data,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int RW = $clog2(MAXR+1);
    localparam int CW = $clog2(MAXC+1);
    localparam int KW = $clog2(MAXK+1);

    typedef enum logic [2:0] {IDLE, INIT, ISSUE, DRAIN, OUTPUT} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] r_reg, orow, row_last, x_row;
    logic [CW-1:0] c_reg, ocol, col_last, x_col;
    logic [KW-1:0] k_reg, k_last;
    logic [KW-1:0] tap_i, tap_j, tap_i_nxt, tap_j_nxt;
    logic [1:0]    drain_cnt;
    logic [XAW-1:0] x_lin;
    logic [WAW-1:0] w_lin;
    logic          job_ok, last_tap, last_col, last_pixel, handshake, load_tap;

    // Job legality and end-of-row/end-of-image conditions.
    always_comb begin
        job_ok     = (k_in != '0) && (int'(k_in) <= int'(r_in)) && (int'(k_in) <= int'(c_in));
        k_last     = k_reg - KW'(1);
        row_last   = RW'(int'(r_reg) - int'(k_reg));
        col_last   = CW'(int'(c_reg) - int'(k_reg));
        last_tap   = (tap_i == k_last) && (tap_j == k_last);
        last_col   = (ocol == col_last);
        last_pixel = last_col && (orow == row_last);
        handshake  = out_valid && out_ready;
    end

    // The address registers always hold the tap being presented, so the next tap is
    // computed here and loaded on entry to ISSUE and on every non-final ISSUE edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        tap_i_nxt = '0;
        tap_j_nxt = '0;
        if (state == ISSUE) begin
            if (tap_j == k_last) begin
                tap_i_nxt = tap_i + KW'(1);
            end else begin
                tap_i_nxt = tap_i;
                tap_j_nxt = tap_j + KW'(1);
            end
        end
        x_row    = orow + RW'(tap_i_nxt);
        x_col    = ocol + CW'(tap_j_nxt);
        x_lin    = XAW'(x_row) * XAW'(c_reg) + XAW'(x_col);
        w_lin    = WAW'(tap_i_nxt) * WAW'(k_reg) + WAW'(tap_j_nxt);
        load_tap = (state == INIT) || ((state == ISSUE) && !last_tap);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && job_ok) state_nxt = INIT;
            INIT:    state_nxt = ISSUE;
            ISSUE:   if (last_tap) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2) state_nxt = OUTPUT;
            OUTPUT:  if (handshake) state_nxt = last_pixel ? IDLE : INIT;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign mac_init_acc = (state == INIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg           <= '0;
            c_reg           <= '0;
            k_reg           <= '0;
            orow            <= '0;
            ocol            <= '0;
            tap_i           <= '0;
            tap_j           <= '0;
            drain_cnt       <= '0;
            x_addr          <= '0;
            w_addr          <= '0;
            mac_init_value  <= '0;
            mac_input_valid <= 1'b0;
            out_data        <= '0;
            out_valid       <= 1'b0;
            done            <= 1'b0;
        end else begin
            done            <= 1'b0;
            // Read data returns one cycle after its address, so valid lags issue by one.
            mac_input_valid <= (state == ISSUE);
            if (load_tap) begin
                tap_i  <= tap_i_nxt;
                tap_j  <= tap_j_nxt;
                x_addr <= x_lin;
                w_addr <= w_lin;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        r_reg          <= r_in;
                        c_reg          <= c_in;
                        k_reg          <= k_in;
                        mac_init_value <= bias;
                        orow           <= '0;
                        ocol           <= '0;
                        done           <= !job_ok;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        drain_cnt <= '0;
                        out_data  <= mac_out;
                        out_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                OUTPUT: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        done      <= last_pixel;
                        if (last_col) begin
                            ocol <= '0;
                            orow <= orow + RW'(1);
                        end else begin
                            ocol <= ocol + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Self-checking bench for conv_tap_sequencer: X/W memories and a pipelined MAC around the DUT,
// expected pixels computed directly from the convolution definition.
module tb_conv_tap_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, out_ready;
    logic [4:0]  r_in, c_in;
    logic [3:0]  k_in;
    logic [15:0] bias, mac_init_value;
    logic        busy, done, mac_init_acc, mac_input_valid, out_valid;
    logic [7:0]  x_addr;
    logic [5:0]  w_addr;
    logic [63:0] mac_out, out_data;

    int n_cmp;
    int n_err;

    conv_tap_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .r_in(r_in), .c_in(c_in), .k_in(k_in), .bias(bias),
        .busy(busy), .done(done), .x_addr(x_addr), .w_addr(w_addr),
        .mac_init_acc(mac_init_acc), .mac_init_value(mac_init_value),
        .mac_input_valid(mac_input_valid), .mac_out(mac_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Environment: synchronous-read memories and a two-stage MAC (multiply, then accumulate).
    logic [15:0] xmem [256];
    logic [15:0] wmem [64];
    logic [15:0] x_q, w_q;
    logic [63:0] prod, acc;
    logic        prod_valid;

    always @(posedge clk) begin
        x_q <= xmem[x_addr];
        w_q <= wmem[w_addr];
        if (reset) begin
            prod_valid <= 1'b0;
            prod       <= '0;
            acc        <= '0;
        end else begin
            prod_valid <= mac_input_valid;
            prod       <= 64'(x_q) * 64'(w_q);
            if (mac_init_acc)    acc <= 64'(mac_init_value);
            else if (prod_valid) acc <= acc + prod;
        end
    end
    assign mac_out = acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_seq();
        for (int i = 0; i < 256; i++) xmem[i] = (i < 9) ? 16'(i + 1) : 16'd0;
        for (int i = 0; i < 64; i++) wmem[i] = 16'd0;
        wmem[0] = 16'd1;
        wmem[3] = 16'd1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) xmem[i] = 16'($urandom);
        for (int i = 0; i < 64; i++) wmem[i] = 16'($urandom);
    endtask

    task automatic check_reset_state();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_init_acc", 64'(mac_init_acc), 64'(0));
        check("rst_in_valid", 64'(mac_input_valid), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_x_addr", 64'(x_addr), 64'(0));
        check("rst_w_addr", 64'(w_addr), 64'(0));
        check("rst_out_data", out_data, 64'(0));
        check("rst_init_value", 64'(mac_init_value), 64'(0));
    endtask

    task automatic run_illegal(input int r, input int c, input int k);
        int bad;
        bad = 0;
        @(negedge clk);
        r_in = 5'(r); c_in = 5'(c); k_in = 4'(k); bias = 16'($urandom); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("illegal_done", 64'(done), 64'(1));
        check("illegal_busy", 64'(busy), 64'(0));
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (busy || done || out_valid || mac_init_acc || mac_input_valid) bad++;
        end
        check("illegal_quiet", 64'(bad), 64'(0));
    endtask

    // One job: start it, randomise inputs that must be ignored while busy, apply
    // backpressure, and compare every presented pixel against the reference list.
    task automatic run_job(input int r, input int c, input int k, input logic [15:0] b,
                           input int bp_pct, input int stall_pix, input int stall_len);
        logic [63:0] expq[$];
        logic [63:0] sum, prev_data;
        logic        ready, prev_wait;
        int npix, cyc, got, budget, first_valid, last_hs, tap, idx;
        int stall_cnt, done_cnt, busy_low, inits, init_bad, overlap;

        for (int orow = 0; orow <= r - k; orow++) begin
            for (int ocol = 0; ocol <= c - k; ocol++) begin
                sum = 64'(b);
                for (int i = 0; i < k; i++) begin
                    for (int j = 0; j < k; j++) begin
                        idx = (orow + i) * c + ocol + j;
                        sum += 64'(xmem[8'(idx)]) * 64'(wmem[6'(i * k + j)]);
                    end
                end
                expq.push_back(sum);
            end
        end
        npix = expq.size();
        budget = 1000 + npix * (k * k + 5) * 8;
        cyc = 0; got = 0; first_valid = -1; last_hs = -1;
        stall_cnt = 0; done_cnt = 0; busy_low = 0; inits = 0; init_bad = 0; overlap = 0;
        prev_wait = 1'b0; prev_data = '0;

        @(negedge clk);
        r_in = 5'(r); c_in = 5'(c); k_in = 4'(k); bias = b; start = 1'b1;
        while (got < npix && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = 1'($urandom_range(0, 1));
            r_in  = 5'($urandom_range(0, 16));
            c_in  = 5'($urandom_range(0, 16));
            k_in  = 4'($urandom_range(0, 8));
            bias  = 16'($urandom);
            if (!busy) busy_low++;
            if (done) done_cnt++;
            if (mac_init_acc) inits++;
            if (mac_init_acc && out_valid) init_bad++;
            if (mac_init_acc && mac_input_valid) overlap++;
            if (got == 0 && cyc <= k * k + 4) begin
                check("init_acc_timing", 64'(mac_init_acc), 64'(cyc == 1));
                check("in_valid_timing", 64'(mac_input_valid), 64'(cyc >= 3 && cyc <= k * k + 2));
                check("early_out_valid", 64'(out_valid), 64'(0));
                if (cyc >= 2 && cyc <= k * k + 1) begin
                    tap = cyc - 2;
                    check("x_addr_seq", 64'(x_addr), 64'((tap / k) * c + tap % k));
                    check("w_addr_seq", 64'(w_addr), 64'(tap));
                end
            end
            if (prev_wait) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", out_data, prev_data);
            end
            ready = 1'($urandom_range(0, 99) >= bp_pct);
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check("out_data", out_data, expq[got]);
                if (got == stall_pix && stall_cnt < stall_len) begin
                    ready = 1'b0;
                    stall_cnt++;
                end
                if (ready) begin
                    got++;
                    last_hs = cyc;
                end
            end
            prev_wait = out_valid && !ready;
            prev_data = out_data;
            out_ready = ready;
        end
        start = 1'b0;

        check("pixel_count", 64'(got), 64'(npix));
        check("first_valid_cycle", 64'(first_valid), 64'(k * k + 5));
        if (bp_pct == 0 && stall_len == 0) check("last_hs_cycle", 64'(last_hs), 64'(npix * (k * k + 5)));
        if (stall_len > 0) check("stall_applied", 64'(stall_cnt), 64'(stall_len));
        check("busy_low_in_job", 64'(busy_low), 64'(0));
        check("done_early", 64'(done_cnt), 64'(0));
        check("init_count", 64'(inits), 64'(npix));
        check("init_in_output", 64'(init_bad), 64'(0));
        check("init_valid_overlap", 64'(overlap), 64'(0));
        if (got == npix) begin
            @(negedge clk);
            out_ready = 1'b0;
            check("done_pulse", 64'(done), 64'(1));
            check("busy_fall", 64'(busy), 64'(0));
            check("out_valid_clear", 64'(out_valid), 64'(0));
            @(negedge clk);
            check("done_single", 64'(done), 64'(0));
            check("idle_stays", 64'(busy), 64'(0));
        end else begin
            @(negedge clk);
            out_ready = 1'b0;
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end
    endtask

    initial begin
        int r, c, k, kmax, quiet;
        n_cmp = 0; n_err = 0;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        r_in = '0; c_in = '0; k_in = '0; bias = '0;
        fill_seq();

        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        @(negedge clk);
        check_reset_state();

        // Identity-diagonal kernel on a 3x3 ramp, without and with bias.
        run_job(3, 3, 2, 16'd0, 0, -1, 0);
        run_job(3, 3, 2, 16'd10, 0, -1, 0);

        fill_random();
        run_job(4, 5, 3, 16'($urandom), 0, -1, 0);

        // Five cycles of backpressure on the second pixel.
        fill_seq();
        run_job(3, 3, 2, 16'd0, 0, 1, 5);

        run_illegal(3, 3, 4);
        run_illegal(3, 3, 0);
        run_illegal(2, 5, 3);

        // Abort in the middle of ISSUE, then rerun the same job cleanly.
        @(negedge clk);
        r_in = 5'd3; c_in = 5'd3; k_in = 4'd2; bias = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy", 64'(busy), 64'(1));
        check("abort_bias_latched", 64'(mac_init_value), 64'(10));
        reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        quiet = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (busy || out_valid || mac_init_acc || mac_input_valid || done) quiet++;
        end
        check("abort_quiet", 64'(quiet), 64'(0));
        run_job(3, 3, 2, 16'd0, 0, -1, 0);

        // Boundary shapes: single output, 1x1 kernel, largest image and kernel.
        fill_random();
        run_job(3, 3, 3, 16'($urandom), 0, -1, 0);
        run_job(5, 4, 1, 16'($urandom), 0, -1, 0);
        run_job(16, 16, 8, 16'($urandom), 0, -1, 0);

        for (int n = 0; n < 8; n++) begin
            fill_random();
            r = int'($urandom_range(1, 7));
            c = int'($urandom_range(1, 7));
            kmax = (r < c) ? r : c;
            if (kmax > 4) kmax = 4;
            k = int'($urandom_range(1, kmax));
            run_job(r, c, k, 16'($urandom), 30, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_tap_sequencer.md
Name: conv_tap_sequencer

Overview:
Control/address stage directly upstream of the pipelined MAC unit in the 2D-convolution accelerator. For each valid output pixel of an R×C input convolved with a K×K kernel, it loads the bias into the MAC, streams K*K tap address pairs into the X and W memories, and drives the MAC valid signal aligned to memory read latency. It then drains the MAC pipeline and presents each finished accumulator value on a valid/ready output port.

Parameters:
INW, 16, data width of bias / MAC init_value
OUTW, 64, MAC accumulator width
MAXR, 16, max input rows
MAXC, 16, max input cols
MAXK, 8, max kernel size
XAW, $clog2(MAXR*MAXC), X memory address width
WAW, $clog2(MAXK*MAXK), W memory address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a convolution; sampled only in IDLE
r_in  in  $clog2(MAXR+1)  input rows R
c_in  in  $clog2(MAXC+1)  input cols C
k_in  in  $clog2(MAXK+1)  kernel size K
bias  in  INW  accumulator initial value
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at job end
x_addr  out  XAW  X memory read address (1-cycle synchronous read)
w_addr  out  WAW  W memory read address (1-cycle synchronous read)
mac_init_acc  out  1  to MAC init_acc
mac_init_value  out  INW  to MAC init_value (latched bias)
mac_input_valid  out  1  to MAC input_valid
mac_out  in  OUTW  MAC accumulator output
out_data  out  OUTW  result pixel
out_valid  out  1  result handshake valid
out_ready  in  1  downstream ready

Behaviour:
- Reset: state IDLE; busy, done, mac_init_acc, mac_input_valid, out_valid = 0; x_addr, w_addr, out_data, mac_init_value = 0; all counters 0. Reset mid-job aborts immediately with no further outputs; the MAC shares the same reset.
- IDLE: on start=1, latch R, C, K, bias. If K==0, K>R or K>C: done=1 for one cycle, stay IDLE, no outputs. Otherwise go to INIT with output row/col (orow, ocol) = 0.
- INIT (1 cycle): mac_init_acc=1. Next state ISSUE with tap counters i=j=0.
- ISSUE (K*K cycles): x_addr=(orow+i)*C+(ocol+j), w_addr=i*K+j; j increments and wraps at K-1, then i increments. mac_input_valid is the issue flag delayed 1 cycle (registered). After tap (K-1,K-1), go to DRAIN.
- DRAIN (exactly 3 cycles): no issue. mac_input_valid is high only in the first DRAIN cycle (last tap). On the edge ending the 3rd DRAIN cycle: out_data <= mac_out, out_valid <= 1, go to OUTPUT.
- OUTPUT: out_valid and out_data are held stable until out_ready=1. On a handshake edge:
  - out_valid <= 0.
  - Advance ocol; it wraps at C-K to 0 and increments orow.
  - If the pixel was (R-K, C-K): done=1 next cycle, go to IDLE.
  - Otherwise go to INIT.
- mac_init_acc and mac_input_valid are never high in the same cycle. The MAC gives init precedence, so any overlap would corrupt the result.
- Per-pixel timing: cycle 0 = start-sampling cycle. INIT is cycle 1, ISSUE is cycles 2..K*K+1, DRAIN is cycles K*K+2..K*K+4. out_valid is first high in cycle K*K+5. With zero backpressure, each following pixel adds K*K+5 cycles.
- Output count = (R-K+1)*(C-K+1), emitted in raster order.
- start is ignored while busy. x_addr and w_addr outside ISSUE hold their last value; their content is don't-care.
- No saturation or truncation is applied; out_data = mac_out bit-exact.

Test Plan:
- R=C=3, K=2, X=1..9 row-major, W={1,0,0,1}, bias=0, out_ready=1 -> outputs 6, 8, 12, 14 in order; done pulses once, 1 cycle after the last handshake; busy falls with it.
- Same job with bias=10 -> outputs 16, 18, 22, 24; first out_valid exactly in cycle 9 (K*K+5) after the start cycle.
- R=4, C=5, K=3, first pixel -> x_addr sequence 0,1,2,5,6,7,10,11,12; w_addr 0..8; mac_input_valid high for exactly 9 cycles, each lagging its address by 1; 6 outputs total.
- Backpressure: hold out_ready=0 for 5 cycles on pixel 2 of the first test -> out_data=8 and out_valid stay stable throughout; no new mac_init_acc until the handshake; final results unchanged.
- Illegal dims: R=3, C=3, K=4, start=1 -> done=1 one cycle later, out_valid never asserts, busy stays 0.
- Reset asserted during ISSUE of pixel 1 -> next cycle all outputs are 0 and state is IDLE; a fresh start then yields the correct full result set (6, 8, 12, 14).
